tft_draw_sequencer: RTL and testbench

TFT_DRAW_SEQUENCER -- requirements
Module: tft_draw_sequencer

---
 rtl/tft_draw_sequencer.sv | 148 ++++++++++++++
 tb/tb_tft_draw_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/tft_draw_sequencer.sv
// Shares one tft_spi transmitter among N_CLIENTS drawing clients: boot clients run once in
// index order, then requesting clients are served by fixed-priority or round-robin arbitration.
module tft_draw_sequencer #(
  parameter int N_CLIENTS    = 3,
  parameter int DATA_W       = 8,
  parameter int BOOT_CLIENTS = 2,
  parameter int MODE         = 0,
  parameter int START_TO     = 4,
  parameter int MAX_GRANT    = 1048576
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [N_CLIENTS-1:0]                          req,
  input  logic [N_CLIENTS-1:0]                          busy,
  input  logic [N_CLIENTS*DATA_W-1:0]                   cl_data,
  input  logic [N_CLIENTS-1:0]                          cl_dc,
  input  logic [N_CLIENTS-1:0]                          cl_transmit,
  output logic [N_CLIENTS-1:0]                          enable,
  output logic [DATA_W-1:0]                             spi_data,
  output logic                                          spi_dc,
  output logic                                          spi_transmit,
  output logic [(N_CLIENTS > 2 ? $clog2(N_CLIENTS) : 1)-1:0] grant_id,
  output logic                                          boot_done,
  output logic                                          timeout_err
);

  localparam int ID_W    = (N_CLIENTS > 2) ? $clog2(N_CLIENTS) : 1;
  localparam int RUN_N   = N_CLIENTS - BOOT_CLIENTS;
  localparam int CNT_MAX = (START_TO > MAX_GRANT) ? START_TO : MAX_GRANT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_START = 2'd1;
  localparam logic [1:0] S_ACTIVE     = 2'd2;
  localparam logic [1:0] S_RELEASE    = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [ID_W-1:0]  boot_idx;
  logic [ID_W-1:0]  rr_off;
  logic             busy_sel;
  logic             run_found;
  logic [ID_W-1:0]  run_id;
  logic [ID_W-1:0]  run_off;

  assign busy_sel = busy[grant_id];
  assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;

  // Run-phase search over offsets from BOOT_CLIENTS; round-robin starts after the last run grant.
  always_comb begin
    int start;
    int pos;
    start     = (MODE == 1) ? int'(rr_off) : 0;
    pos       = 0;
    run_found = 1'b0;
    run_id    = '0;
    run_off   = '0;
    for (int off = 0; off < RUN_N; off++) begin
      pos = start + off;
      if (pos >= RUN_N) pos = pos - RUN_N;
      if (!run_found && req[BOOT_CLIENTS + pos]) begin
        run_found = 1'b1;
        run_id    = ID_W'(BOOT_CLIENTS + pos);
        run_off   = ID_W'(pos);
      end
    end
  end

  always_comb begin
    spi_data     = '0;
    spi_dc       = 1'b0;
    spi_transmit = 1'b0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      if (enable[k]) begin
        spi_data     = spi_data | cl_data[k*DATA_W +: DATA_W];
        spi_dc       = spi_dc | cl_dc[k];
        spi_transmit = spi_transmit | cl_transmit[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      boot_idx    <= '0;
      rr_off      <= '0;
      enable      <= '0;
      grant_id    <= '0;
      boot_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!boot_done) begin
            if (BOOT_CLIENTS == 0) begin
              boot_done <= 1'b1;
            end else begin
              enable   <= N_CLIENTS'(1) << boot_idx;
              grant_id <= boot_idx;
              cnt      <= '0;
              state    <= S_WAIT_START;
            end
          end else if (run_found) begin
            enable   <= N_CLIENTS'(1) << run_id;
            grant_id <= run_id;
            cnt      <= '0;
            state    <= S_WAIT_START;
            rr_off   <= (run_off == ID_W'(RUN_N - 1)) ? '0 : run_off + 1'b1;
          end
        end
        S_WAIT_START: begin
          // A client that never starts is treated as having nothing to draw.
          if (busy_sel) begin
            state <= S_ACTIVE;
            cnt   <= '0;
          end else if (cnt == CNT_W'(START_TO - 1)) begin
            state  <= S_RELEASE;
            enable <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_ACTIVE: begin
          if (!busy_sel) begin
            state  <= S_RELEASE;
            enable <= '0;
          end else if (cnt == CNT_W'(MAX_GRANT - 1)) begin
            state       <= S_RELEASE;
            enable      <= '0;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= S_IDLE;
          if (!boot_done) begin
            boot_idx <= boot_idx + 1'b1;
            if (boot_idx == ID_W'(BOOT_CLIENTS - 1)) boot_done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tft_draw_sequencer.sv
// Directed bench: boot sequence, start timeout, MAX_GRANT timeout, mux, reset mid-grant,
// and round-robin versus fixed-priority arbitration on a 4-client configuration.
module tb_tft_draw_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 3 clients, 2 boot clients, fixed priority, short MAX_GRANT
  logic [2:0]  req_a = '0, busy_a = '0, dc_a = '0, tx_a = '0;
  logic [23:0] data_a = '0;
  logic [2:0]  en_a;
  logic [7:0]  spid_a;
  logic        spidc_a, spitx_a, bd_a, to_a;
  logic [1:0]  gid_a;

  tft_draw_sequencer #(.N_CLIENTS(3), .DATA_W(8), .BOOT_CLIENTS(2), .MODE(0),
                       .START_TO(4), .MAX_GRANT(16)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .busy(busy_a), .cl_data(data_a), .cl_dc(dc_a),
    .cl_transmit(tx_a), .enable(en_a), .spi_data(spid_a), .spi_dc(spidc_a),
    .spi_transmit(spitx_a), .grant_id(gid_a), .boot_done(bd_a), .timeout_err(to_a));

  // Instances B (round-robin) and C (fixed priority): 4 clients, 1 boot client, shared inputs
  logic [3:0]  req_b = 4'b1110, busy_b = '0, dc_b = '0, tx_b = '0;
  logic [31:0] data_b = '0;
  logic [3:0]  en_b, en_c;
  logic [7:0]  spid_b, spid_c;
  logic        spidc_b, spitx_b, bd_b, to_b, spidc_c, spitx_c, bd_c, to_c;
  logic [1:0]  gid_b, gid_c;

  tft_draw_sequencer #(.N_CLIENTS(4), .BOOT_CLIENTS(1), .MODE(1)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .busy(busy_b), .cl_data(data_b), .cl_dc(dc_b),
    .cl_transmit(tx_b), .enable(en_b), .spi_data(spid_b), .spi_dc(spidc_b),
    .spi_transmit(spitx_b), .grant_id(gid_b), .boot_done(bd_b), .timeout_err(to_b));

  tft_draw_sequencer #(.N_CLIENTS(4), .BOOT_CLIENTS(1), .MODE(0)) dut_c (
    .clk(clk), .rst(rst), .req(req_b), .busy(busy_b), .cl_data(data_b), .cl_dc(dc_b),
    .cl_transmit(tx_b), .enable(en_c), .spi_data(spid_c), .spi_dc(spidc_c),
    .spi_transmit(spitx_c), .grant_id(gid_c), .boot_done(bd_c), .timeout_err(to_c));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_b[5];
    exp_b = '{1, 2, 3, 1, 2};

    step(2);
    chk("rst_enable", 32'(en_a), 32'h0);
    chk("rst_grant_id", 32'(gid_a), 32'h0);
    chk("rst_boot_done", 32'(bd_a), 32'h0);
    chk("rst_timeout", 32'(to_a), 32'h0);
    chk("rst_spi_data", 32'(spid_a), 32'h0);
    rst = 1'b1;

    // Boot client 0: busy one cycle after enable, held for 10 cycles
    step(1);
    chk("boot0_enable", 32'(en_a), 32'h1);
    chk("boot0_gid", 32'(gid_a), 32'h0);
    busy_a[0] = 1'b1;
    data_a[7:0] = 8'hA5; dc_a[0] = 1'b1; tx_a[0] = 1'b1;
    data_a[15:8] = 8'h3C; tx_a[1] = 1'b1;
    step(1);
    chk("mux_data", 32'(spid_a), 32'hA5);
    chk("mux_dc", 32'(spidc_a), 32'h1);
    chk("mux_tx", 32'(spitx_a), 32'h1);
    step(9);
    chk("boot0_hold", 32'(en_a), 32'h1);
    busy_a[0] = 1'b0;
    step(1);
    chk("boot0_release", 32'(en_a), 32'h0);
    chk("mux_idle_data", 32'(spid_a), 32'h0);
    chk("mux_idle_tx", 32'(spitx_a), 32'h0);
    step(1);
    chk("gap_cycle2", 32'(en_a), 32'h0);
    step(1);
    chk("boot1_enable", 32'(en_a), 32'h2);
    chk("boot1_gid", 32'(gid_a), 32'h1);

    // Boot client 1 never starts; a stray busy from client 2 must be ignored
    busy_a[2] = 1'b1;
    step(3);
    chk("start_to_hold", 32'(en_a), 32'h2);
    step(1);
    chk("start_to_release", 32'(en_a), 32'h0);
    chk("start_to_noerr", 32'(to_a), 32'h0);
    chk("boot_done_pending", 32'(bd_a), 32'h0);
    busy_a[2] = 1'b0;
    step(1);
    chk("boot_done_set", 32'(bd_a), 32'h1);
    step(3);
    chk("run_no_req", 32'(en_a), 32'h0);

    // Run phase: client 2 requests, then holds busy until MAX_GRANT forces release
    req_a[2] = 1'b1;
    step(1);
    chk("run2_enable", 32'(en_a), 32'h4);
    chk("run2_gid", 32'(gid_a), 32'h2);
    req_a[2] = 1'b0;
    busy_a[2] = 1'b1;
    data_a[23:16] = 8'h77; tx_a[2] = 1'b1;
    step(16);
    chk("maxg_hold", 32'(en_a), 32'h4);
    chk("maxg_noerr_yet", 32'(to_a), 32'h0);
    chk("mux_client2", 32'(spid_a), 32'h77);
    step(1);
    chk("maxg_release", 32'(en_a), 32'h0);
    chk("maxg_err", 32'(to_a), 32'h1);
    chk("maxg_last_gid", 32'(gid_a), 32'h2);
    busy_a[2] = 1'b0;
    step(5);
    chk("err_sticky", 32'(to_a), 32'h1);

    // Reset in the middle of a client-2 grant
    req_a[2] = 1'b1;
    step(1);
    chk("regrant2", 32'(en_a), 32'h4);
    req_a[2] = 1'b0;
    busy_a[2] = 1'b1;
    step(1);
    chk("regrant2_active", 32'(en_a), 32'h4);
    rst = 1'b0;
    step(1);
    chk("midrst_enable", 32'(en_a), 32'h0);
    chk("midrst_spi", 32'(spid_a), 32'h0);
    chk("midrst_tx", 32'(spitx_a), 32'h0);
    chk("midrst_err", 32'(to_a), 32'h0);
    chk("midrst_bd", 32'(bd_a), 32'h0);
    rst = 1'b1;
    busy_a[2] = 1'b0;
    step(1);
    chk("reboot_enable", 32'(en_a), 32'h1);
    chk("reboot_gid", 32'(gid_a), 32'h0);
    chk("b_boot_enable", 32'(en_b), 32'h1);
    chk("c_boot_enable", 32'(en_c), 32'h1);

    // Each grant lasts START_TO cycles plus a 2-cycle gap, so grants recur every 6 cycles
    for (int i = 0; i < 5; i++) begin
      step(6);
      chk($sformatf("rr_gid_%0d", i), 32'(gid_b), 32'(exp_b[i]));
      chk($sformatf("rr_en_%0d", i), 32'(en_b), 32'(1) << exp_b[i]);
      chk($sformatf("fp_gid_%0d", i), 32'(gid_c), 32'h1);
      chk($sformatf("fp_en_%0d", i), 32'(en_c), 32'h2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
